// File: rtl/pwm_from_count.sv
// PWM generator driven by an upstream free-running counter, with boundary-aligned
// duty updates (load/busy handshake) and a sticky count-sequence error monitor.
module pwm_from_count #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned RESET_DUTY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_load,
  input  logic             err_clr,
  output logic             pwm_out,
  output logic             period_start,
  output logic             duty_busy,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(RESET_DUTY);

  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             err_q, err_d;

  logic             boundary;
  logic             take_pend;
  logic             illegal;
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] eff;

  // A held zero is not a new period; the first zero after reset is.
  assign boundary  = (count == '0) && (!prev_vld_q || (prev_q != '0));
  assign take_pend = boundary && pend_vld_q;
  assign prev_inc  = prev_q + WIDTH'(1);
  assign illegal   = prev_vld_q && !((count == prev_q) || (count == prev_inc) || (count == '0));
  assign eff       = take_pend ? pend_q : active_q;

  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (take_pend) begin
      active_d = pend_q;
    end
    // A load coinciding with the boundary queues for the following period.
    if (duty_load) begin
      pend_d     = duty;
      pend_vld_d = 1'b1;
    end else if (take_pend) begin
      pend_vld_d = 1'b0;
    end
    pwm_d = (count < eff);
    ps_d  = boundary;
    if (illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= RST_DUTY;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      pwm_q      <= 1'b0;
      ps_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      prev_q     <= count;
      prev_vld_q <= 1'b1;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
      err_q      <= err_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_busy    = pend_vld_q;
  assign seq_err      = err_q;

endmodule
